// File: rtl/mult_div_unit_pkg.sv
// Shared MIPS HI/LO unit definitions: MD_* internal op codes, FUN_* funct codes and FSM states.
// Used by the decoder, the hazard unit and mult_div_unit.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_NONE  = 3'd7;

  localparam logic [5:0] FUN_MFHI  = 6'h10;
  localparam logic [5:0] FUN_MTHI  = 6'h11;
  localparam logic [5:0] FUN_MFLO  = 6'h12;
  localparam logic [5:0] FUN_MTLO  = 6'h13;
  localparam logic [5:0] FUN_MULT  = 6'h18;
  localparam logic [5:0] FUN_MULTU = 6'h19;
  localparam logic [5:0] FUN_DIV   = 6'h1a;
  localparam logic [5:0] FUN_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // MFHI/MFLO read HI/LO through the register path and never issue to the unit.
  function automatic logic [2:0] fun_to_mdop(input logic [5:0] fun);
    logic [2:0] op;
    case (fun)
      FUN_MULT:  op = MD_MULT;
      FUN_MULTU: op = MD_MULTU;
      FUN_DIV:   op = MD_DIV;
      FUN_DIVU:  op = MD_DIVU;
      FUN_MTHI:  op = MD_MTHI;
      FUN_MTLO:  op = MD_MTLO;
      default:   op = MD_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// One restoring-division step on unsigned magnitudes: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference and set the quotient bit when it does not borrow.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] diff_s;
  logic             fits_s;

  assign shifted_s = {rem, quo[WIDTH-1]};
  assign diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
  assign fits_s    = ~diff_s[WIDTH+1];

  // Either result is below the divisor, so it always fits back into WIDTH bits.
  assign rem_next = fits_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits_s};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU over WIDTH+1 cycles, MTHI/MTLO direct).
// Optional MDU_FAST_MULT_EN: multiplies bypass RUN and use a single-cycle product in FIX.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mdu_state_e         state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [2*WIDTH-1:0] acc_r, acc_s;      // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   mcand_r, mcand_s;  // multiplicand or divisor magnitude
  logic               is_div_r, is_div_s;
  logic               sa_r, sa_s, sb_r, sb_s;
  logic               dz_r, dz_s;
  logic [WIDTH-1:0]   hi_r, hi_s, lo_r, lo_s;
  logic               busy_r;

  logic               op_signed_s, op_sa_s, op_sb_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH-1:0]   div_rem_s, div_quo_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0]   rem_fix_s, quo_fix_s;

  assign op_signed_s = md_is_signed(mdOp);
  assign op_sa_s     = op_signed_s & opA[WIDTH-1];
  assign op_sb_s     = op_signed_s & opB[WIDTH-1];
  assign a_mag_s     = op_sa_s ? -opA : opA;
  assign b_mag_s     = op_sb_s ? -opB : opB;

  assign mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .rem      (acc_r[2*WIDTH-1:WIDTH]),
    .quo      (acc_r[WIDTH-1:0]),
    .divisor  (mcand_r),
    .rem_next (div_rem_s),
    .quo_next (div_quo_s)
  );

`ifdef MDU_FAST_MULT_EN
  assign prod_s = {{WIDTH{1'b0}}, mcand_r} * {{WIDTH{1'b0}}, acc_r[WIDTH-1:0]};
`else
  assign prod_s = acc_r;
`endif

  assign prod_fix_s = (sa_r ^ sb_r) ? -prod_s : prod_s;
  assign rem_fix_s  = sa_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
  // Divide by zero leaves the all-ones quotient unsigned; the remainder fixup then restores opA.
  assign quo_fix_s  = dz_r ? {WIDTH{1'b1}}
                    : ((sa_r ^ sb_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0]);

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    acc_s    = acc_r;
    mcand_s  = mcand_r;
    is_div_s = is_div_r;
    sa_s     = sa_r;
    sb_s     = sb_r;
    dz_s     = dz_r;
    hi_s     = hi_r;
    lo_s     = lo_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (mdOp)
            MD_MTHI: hi_s = opA;
            MD_MTLO: lo_s = opA;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              is_div_s = md_is_div(mdOp);
              sa_s     = op_sa_s;
              sb_s     = op_sb_s;
              dz_s     = (opB == {WIDTH{1'b0}});
              cnt_s    = {CW{1'b0}};
              if (md_is_div(mdOp)) begin
                acc_s   = {{WIDTH{1'b0}}, a_mag_s};
                mcand_s = b_mag_s;
                state_s = ST_RUN;
              end else begin
                acc_s   = {{WIDTH{1'b0}}, b_mag_s};
                mcand_s = a_mag_s;
`ifdef MDU_FAST_MULT_EN
                state_s = ST_FIX;
`else
                state_s = ST_RUN;
`endif
              end
            end
            default: ;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (is_div_r) begin
          acc_s = {div_rem_s, div_quo_s};
        end else begin
          acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_r == CNT_LAST) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FIX: begin
        if (is_div_r) begin
          hi_s = rem_fix_s;
          lo_s = quo_fix_s;
        end else begin
          hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_s = prod_fix_s[WIDTH-1:0];
        end
        state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      dz_r     <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      acc_r    <= acc_s;
      mcand_r  <= mcand_s;
      is_div_r <= is_div_s;
      sa_r     <= sa_s;
      sb_r     <= sb_s;
      dz_r     <= dz_s;
      hi_r     <= hi_s;
      lo_r     <= lo_s;
      busy_r   <= (state_s != ST_IDLE);
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: vector table plus hand-written corner sequences.
// Honours MDU_FAST_MULT_EN for the expected multiply latency.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int WIDTH   = 32;
  localparam int DIV_LAT = WIDTH + 1;
`ifdef MDU_FAST_MULT_EN
  localparam int MULT_LAT = 1;
`else
  localparam int MULT_LAT = WIDTH + 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mdOp = 3'd0;
  logic [31:0] opA = 32'd0;
  logic [31:0] opB = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mdOp    (mdOp),
    .opA     (opA),
    .opB     (opB),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts busy samples (taken #1 after each edge) until busy drops; n already holds earlier samples.
  task automatic wait_idle(input string name, inout int n);
    int g;
    g = 0;
    while (busy === 1'b1 && g < 200) begin
      n++;
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still high after %0d cycles, expected low", name, g);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    mdOp  = op;
    opA   = a;
    opB   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    int exp_lat;

    vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{MD_MULTU, 32'h12345678, 32'h00000009, 32'h00000000, 32'hA3D70A38};
    vecs[6]  = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[9]  = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{MD_MULT,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[12] = '{MD_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[13] = '{MD_DIVU,  32'h00000005, 32'h0000000A, 32'h00000005, 32'h00000000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // MTHI then MTLO back-to-back; busy never rises
    @(negedge clk);
    start = 1'b1;
    mdOp  = MD_MTHI;
    opA   = 32'h00001234;
    @(posedge clk);
    #1;
    check("mthi_busy", {31'd0, busy}, 32'd0);
    mdOp = MD_MTLO;
    opA  = 32'h00005678;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h00001234);
    check("mtlo_lo", lo, 32'h00005678);

    // Unknown op codes are ignored
    for (int k = 6; k < 8; k++) begin
      logic [2:0] bad_op;
      bad_op = 3'(k);
      issue(bad_op, 32'hDEADBEEF, 32'h00000003);
      check($sformatf("badop%0d_busy", k), {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("badop%0d_hi", k), hi, 32'h00001234);
      check($sformatf("badop%0d_lo", k), lo, 32'h00005678);
    end

    // Vector table
    for (int i = 0; i < 14; i++) begin
      exp_lat = md_is_div(vecs[i].op) ? DIV_LAT : MULT_LAT;
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      n = 0;
      wait_idle($sformatf("vec%0d", i), n);
      check($sformatf("vec%0d_latency", i), 32'(n), 32'(exp_lat));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
    end

    // DIVU presented while a MULT is in flight is dropped
    @(negedge clk);
    start = 1'b1;
    mdOp  = MD_MULT;
    opA   = 32'd6;
    opB   = 32'd7;
    @(posedge clk);
    #1;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    mdOp = MD_DIVU;
    opA  = 32'd100;
    opB  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    wait_idle("overlap", n);
    check("overlap_latency", 32'(n), 32'(MULT_LAT));
    check("overlap_hi", hi, 32'd0);
    check("overlap_lo", lo, 32'd42);
    repeat (40) @(posedge clk);
    #1;
    check("overlap_idle", {31'd0, busy}, 32'd0);
    check("overlap_hold_hi", hi, 32'd0);
    check("overlap_hold_lo", lo, 32'd42);

    // Reset mid-operation aborts and clears HI/LO
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    check("midop_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_stays_idle", {31'd0, busy}, 32'd0);
    check("abort_lo_held", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
